demorgan_checker: RTL

- Hardware response checker for the two-input De Morgan gate block: the receiving and judging end of the truth-table exercise, where the bench is the driving end.
- Accepts observed samples (A, B and the six gate outputs) over a valid/ready handshake and checks each against golden logic.
- Tracks coverage of all four input combinations and counts mismatches.
- Reports pass/fail once coverage is complete or on request.

---
 rtl/demorgan_pkg.sv | 21 ++
 rtl/demorgan_golden.sv | 23 ++
 rtl/demorgan_checker.sv | 134 +++++++++++++
 3 files changed

// File: rtl/demorgan_pkg.sv
// Shared definitions for the De Morgan response checker.
//   state_t      : checker FSM states (IDLE, RUN, DONE)
//   CHK_*        : bit positions of each gate check in mismatch/fail vectors
//   NUM_CHECKS   : number of gate outputs checked per sample
package demorgan_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int NUM_CHECKS    = 6;
   localparam int CHK_NA        = 0;
   localparam int CHK_NB        = 1;
   localparam int CHK_ANANDB    = 2;
   localparam int CHK_NAORNB    = 3;
   localparam int CHK_NORAB     = 4;
   localparam int CHK_NANANDNB  = 5;

endpackage

// File: rtl/demorgan_golden.sv
// Combinational reference model of the two-input De Morgan gate block.
// Ports:
//   a, b     : stimulus bits
//   exp_vec  : expected gate outputs, indexed by the CHK_* constants
module demorgan_golden
   import demorgan_pkg::*;
(
   input  logic                  a,
   input  logic                  b,
   output logic [NUM_CHECKS-1:0] exp_vec
);

   always_comb begin
      exp_vec               = '0;
      exp_vec[CHK_NA]       = ~a;
      exp_vec[CHK_NB]       = ~b;
      exp_vec[CHK_ANANDB]   = ~(a & b);
      exp_vec[CHK_NAORNB]   = ~a | ~b;
      exp_vec[CHK_NORAB]    = ~(a | b);
      exp_vec[CHK_NANANDNB] = ~a & ~b;
   end

endmodule

// File: rtl/demorgan_checker.sv
// Response checker for the two-input De Morgan gate block. Accepts observed
// samples over valid/ready, compares them with the golden model, tracks
// coverage of the four input combinations and reports pass/fail.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   start, finish   : begin a run (clears statistics) / force completion
//   in_valid/ready  : sample handshake; in_ready is high exactly in RUN
//   in_a, in_b      : stimulus bits of the sample
//   in_na..in_nanandnb : observed gate outputs
//   busy, done, pass: status; pass is meaningful while done
//   err_count       : saturating count of mismatching samples
//   fail_mask       : sticky per-check failure flags (CHK_* order)
//   coverage        : bit {a,b} set once that combination was accepted
//   sample_count    : saturating count of accepted samples
module demorgan_checker
   import demorgan_pkg::*;
#(
   parameter int ERR_W       = 8,
   parameter int CNT_W       = 8,
   parameter int MIN_SAMPLES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  finish,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_a,
   input  logic                  in_b,
   input  logic                  in_na,
   input  logic                  in_nb,
   input  logic                  in_anandb,
   input  logic                  in_naornb,
   input  logic                  in_norab,
   input  logic                  in_nanandnb,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ERR_W-1:0]      err_count,
   output logic [NUM_CHECKS-1:0] fail_mask,
   output logic [3:0]            coverage,
   output logic [CNT_W-1:0]      sample_count
);

   state_t                state_q, state_d;
   logic                  ready_q, ready_d;
   logic                  pass_q, pass_d;
   logic [ERR_W-1:0]      err_q, err_d;
   logic [NUM_CHECKS-1:0] mask_q, mask_d;
   logic [3:0]            cov_q, cov_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic [NUM_CHECKS-1:0] golden;
   logic [NUM_CHECKS-1:0] observed;
   logic [NUM_CHECKS-1:0] mism;
   logic                  xfer;

   demorgan_golden u_golden (
      .a       (in_a),
      .b       (in_b),
      .exp_vec (golden)
   );

   assign observed = {in_nanandnb, in_norab, in_naornb, in_anandb, in_nb, in_na};
   assign mism     = observed ^ golden;
   assign xfer     = in_valid && ready_q;

   always_comb begin
      state_d = state_q;
      pass_d  = pass_q;
      err_d   = err_q;
      mask_d  = mask_q;
      cov_d   = cov_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               pass_d  = 1'b0;
               err_d   = '0;
               mask_d  = '0;
               cov_d   = '0;
               cnt_d   = '0;
            end
         end
         RUN: begin
            if (xfer) begin
               mask_d = mask_q | mism;
               if ((|mism) && (err_q != '1)) err_d = err_q + ERR_W'(1);
               cov_d[{in_a, in_b}] = 1'b1;
               if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            end
            // Completion looks at post-update statistics so a sample arriving
            // with finish (or completing coverage) is included in the verdict.
            if (finish || ((cov_d == 4'hF) && (cnt_d >= CNT_W'(MIN_SAMPLES)))) begin
               state_d = DONE;
               pass_d  = (err_d == '0) && (cov_d == 4'hF);
            end
         end
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == RUN);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         mask_q  <= '0;
         cov_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         mask_q  <= mask_d;
         cov_q   <= cov_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready     = ready_q;
   assign busy         = (state_q == RUN);
   assign done         = (state_q == DONE);
   assign pass         = pass_q;
   assign err_count    = err_q;
   assign fail_mask    = mask_q;
   assign coverage     = cov_q;
   assign sample_count = cnt_q;

endmodule
